// File: rtl/fsm_010_sched.sv
// Round-robin scheduler that streams one requester's serial bits into a shared 010 detector
// and credits detector matches back to the owning channel. Optional macro: FSM_SCHED_SAT_EN.
module fsm_010_sched #(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [3:0]         bit_in,
    output logic [3:0]         gnt,
    output logic               det_x,
    output logic               det_clr,
    input  logic               det_y,
    output logic [3:0]         match_pulse,
    output logic [4*CNT_W-1:0] match_cnt,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN
    } state_t;

    localparam int unsigned BEAT_W = 8;

    state_t            r_state;
    logic [1:0]        r_last_idx;
    logic [1:0]        r_winner;
    logic [1:0]        r_owner;
    logic              r_owner_vld;
    logic [BEAT_W-1:0] r_beat;
    logic [3:0]        r_gnt;
    logic              r_det_clr;
    logic              r_busy;
    logic [3:0]        r_match_pulse;
    logic [CNT_W-1:0]  r_cnt [4];

    logic              w_any_req;
    logic [1:0]        w_rr_idx;
    logic              w_win_req;
    logic              w_last_beat;
    logic [CNT_W-1:0]  w_cnt_cur;
    logic [CNT_W-1:0]  w_cnt_next;

    // Scan from farthest to nearest so the nearest requester after last_idx wins.
    always_comb begin
        logic [1:0] v_idx;
        w_any_req = |req;
        w_rr_idx  = r_last_idx;
        v_idx     = '0;
        for (int unsigned k = 4; k >= 1; k--) begin
            v_idx = r_last_idx + 2'(k);
            if (req[v_idx]) begin
                w_rr_idx = v_idx;
            end
        end
    end

    always_comb begin
        w_win_req   = req[r_winner];
        w_last_beat = (r_beat == BEAT_W'(BURST_LEN - 1));
    end

    always_comb begin
        w_cnt_cur = r_cnt[r_owner];
`ifdef FSM_SCHED_SAT_EN
        w_cnt_next = (w_cnt_cur == '1) ? w_cnt_cur : w_cnt_cur + CNT_W'(1);
`else
        w_cnt_next = w_cnt_cur + CNT_W'(1);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_last_idx    <= 2'd3;
            r_winner      <= '0;
            r_owner       <= '0;
            r_owner_vld   <= 1'b0;
            r_beat        <= '0;
            r_gnt         <= '0;
            r_det_clr     <= 1'b0;
            r_busy        <= 1'b0;
            r_match_pulse <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_match_pulse <= '0;
            r_owner_vld   <= 1'b0;

            // det_y reflects the bit consumed one edge earlier, which owner_vld also tracks.
            if (det_y && r_owner_vld) begin
                r_match_pulse[r_owner] <= 1'b1;
                r_cnt[r_owner]         <= w_cnt_next;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_winner   <= w_rr_idx;
                        r_last_idx <= w_rr_idx;
                        r_det_clr  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    r_det_clr <= 1'b0;
                    r_beat    <= '0;
                    r_gnt     <= 4'b0001 << r_winner;
                    r_state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_win_req) begin
                        r_owner     <= r_winner;
                        r_owner_vld <= 1'b1;
                        r_beat      <= r_beat + BEAT_W'(1);
                    end
                    if (!w_win_req || w_last_beat) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_gnt     <= '0;
                    r_busy    <= 1'b0;
                    r_det_clr <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // The serial bit must reach the detector in the same cycle it is presented.
    always_comb begin
        det_x = (r_state == ST_RUN) ? bit_in[r_winner] : 1'b1;
    end

    always_comb begin
        gnt         = r_gnt;
        det_clr     = r_det_clr;
        busy        = r_busy;
        match_pulse = r_match_pulse;
        match_cnt   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            match_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

endmodule

// File: tb/tb_fsm_010_sched.sv
// Directed bench for fsm_010_sched with a behavioural Moore 010 detector on det_x/det_y.
module tb_fsm_010_sched;

    localparam int unsigned BL = 8;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    req = '0;
    logic [3:0]    bit_in = '1;
    logic [3:0]    gnt;
    logic          det_x;
    logic          det_clr;
    logic          det_y;
    logic [3:0]    match_pulse;
    logic [4*CW-1:0] match_cnt;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;
    int pulse_tot [4] = '{default: 0};

    always #5 clk = ~clk;

    fsm_010_sched #(.BURST_LEN(BL), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .bit_in      (bit_in),
        .gnt         (gnt),
        .det_x       (det_x),
        .det_clr     (det_clr),
        .det_y       (det_y),
        .match_pulse (match_pulse),
        .match_cnt   (match_cnt),
        .busy        (busy)
    );

    typedef enum logic [1:0] {D_IDLE, D_0, D_01, D_010} det_t;
    det_t d_st;

    always @(posedge clk or negedge rst) begin
        if (!rst) d_st <= D_IDLE;
        else if (det_clr) d_st <= D_IDLE;
        else begin
            case (d_st)
                D_IDLE:  d_st <= det_x ? D_IDLE : D_0;
                D_0:     d_st <= det_x ? D_01   : D_0;
                D_01:    d_st <= det_x ? D_IDLE : D_010;
                default: d_st <= det_x ? D_01   : D_0;
            endcase
        end
    end
    assign det_y = (d_st == D_010);

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (match_pulse[i] === 1'b1) pulse_tot[i] <= pulse_tot[i] + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_grant(output int w);
        w = 0;
        while (gnt === 4'b0000 && w < 20) begin
            step();
            w++;
        end
    endtask

    task automatic run_burst(input string tag, input logic [3:0] exp_gnt, input int exp_wait);
        int w;
        int len;
        wait_grant(w);
        check($sformatf("%s wait", tag), w, exp_wait);
        check($sformatf("%s gnt", tag), gnt, exp_gnt);
        len = 0;
        while (gnt === exp_gnt && len < 300) begin
            step();
            len++;
        end
        check($sformatf("%s len", tag), len, BL);
        check($sformatf("%s idle busy", tag), busy, 0);
    endtask

    task automatic stream(input string tag, input int ch, input logic [7:0] bits,
                          input int n, output logic [7:0] pulses);
        int w;
        logic [3:0] exp_g;
        pulses = '0;
        exp_g  = 4'b0001 << ch;
        wait_grant(w);
        check($sformatf("%s gnt", tag), gnt, exp_g);
        for (int j = 0; j < n; j++) begin
            pulses[j] = (match_pulse != 4'b0000);
            bit_in[ch] = bits[j];
            step();
        end
        bit_in = '1;
    endtask

    initial begin
        logic [7:0] pl;
        int snap;

        // Reset with every channel requesting.
        req = 4'hF;
        step(); step();
        check("rst gnt", gnt, 0);
        check("rst busy", busy, 0);
        check("rst cnt", match_cnt, 0);
        check("rst pulse", match_pulse, 0);
        check("rst det_x", det_x, 1);
        check("rst det_clr", det_clr, 0);

        rst = 1'b1;
        step();
        check("clr det_clr", det_clr, 1);
        check("clr busy", busy, 1);
        check("clr gnt", gnt, 0);

        // Round-robin with all requests held.
        run_burst("rr0", 4'b0001, 1);
        run_burst("rr1", 4'b0010, 2);
        run_burst("rr2", 4'b0100, 2);
        run_burst("rr3", 4'b1000, 2);
        run_burst("rr4", 4'b0001, 2);
        req = 4'h0;
        step();
        check("rr cnt", match_cnt, 0);

        // Single channel 2: 0,1,0,1,0,0,0,0.
        snap = pulse_tot[2];
        req = 4'b0100;
        stream("ch2", 2, 8'h0A, 8, pl);
        check("ch2 pulse timing", pl, 8'h50);
        req = 4'h0;
        check("ch2 end gnt", gnt, 0);
        check("ch2 end busy", busy, 0);
        step(); step();
        check("ch2 cnt", match_cnt, 8'h20);
        check("ch2 pulses", pulse_tot[2] - snap, 2);

        // No match across grants: ch0 ends 0,1 and ch1 begins 0.
        req = 4'b0011;
        stream("span ch0", 0, 8'hBF, 8, pl);
        check("span ch0 pulses", pl, 0);
        stream("span ch1", 1, 8'hFC, 8, pl);
        check("span ch1 pulses", pl, 0);
        req = 4'h0;
        step(); step();
        check("span cnt", match_cnt, 8'h20);

        // Early drop on ch1 after 0,1,0.
        req = 4'b0010;
        stream("drop", 1, 8'h02, 3, pl);
        check("drop pulses", pl, 0);
        req = 4'h0;
        check("drop run gnt", gnt, 4'b0010);
        check("drop pre pulse", match_pulse, 0);
        step();
        check("drop credit pulse", match_pulse, 4'b0010);
        check("drop gnt", gnt, 0);
        check("drop busy", busy, 0);
        check("drop cnt", match_cnt, 8'h24);

        // Arbitration resumes: ch3 beats held ch1; then five matches on ch3.
        snap = pulse_tot[3];
        req = 4'b1010;
        stream("sat b1", 3, 8'hAA, 8, pl);
        check("sat b1 pulses", pl, 8'h50);
        check("sat b1 idle pulse", match_pulse, 4'b1000);
        req = 4'b1000;
        stream("sat b2", 3, 8'h5A, 8, pl);
        check("sat b2 pulses", pl, 8'h10);
        req = 4'h0;
        check("sat b2 pre pulse", match_pulse, 0);
        step();
        check("sat final credit", match_pulse, 4'b1000);
        step(); step();
`ifdef FSM_SCHED_SAT_EN
        check("sat cnt", match_cnt, 8'hE4);
`else
        check("sat cnt", match_cnt, 8'h64);
`endif
        check("sat pulses", pulse_tot[3] - snap, 5);

        // Reset mid-RUN with a match pending.
        req = 4'b0001;
        stream("mid", 0, 8'h02, 3, pl);
        rst = 1'b0;
        #1;
        check("mid rst gnt", gnt, 0);
        check("mid rst busy", busy, 0);
        check("mid rst det_x", det_x, 1);
        check("mid rst cnt", match_cnt, 0);
        check("mid rst pulse", match_pulse, 0);
        step(); step();
        req = 4'hF;
        rst = 1'b1;
        step();
        check("mid clr det_clr", det_clr, 1);
        run_burst("mid rr0", 4'b0001, 1);
        req = 4'h0;
        step();
        check("mid cnt", match_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
